ascii_dec_parser: RTL and testbench

//  Synthesizable, parametrised successor to the console single-digit reader.

---
 rtl/ascii_dec_pkg.sv | 30 +++
 rtl/ascii_char_class.sv | 30 +++
 rtl/ascii_dec_parser.sv | 231 +++++++++++++++++++++++
 tb/tb_ascii_dec_parser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_dec_pkg.sv
// Shared types and constants for the ASCII decimal parser.
// Optional feature macro used by the parser: ASCII_DEC_SIGNED_EN.
package ascii_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SKIP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BADCHAR = 2'd1,
        ERR_OVF     = 2'd2,
        ERR_EMPTY   = 2'd3
    } err_e;

    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    // Even parity of a result word, handy for downstream integrity checking.
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ascii_char_class.sv
// Combinational classifier: one ASCII byte -> digit / newline / CR / minus flags
// plus the decimal digit value (zero when the byte is not a digit).
module ascii_char_class
    import ascii_dec_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       is_digit_o,
    output logic       is_nl_o,
    output logic       is_cr_o,
    output logic       is_minus_o,
    output logic [3:0] digit_o
);

    logic [7:0] diff_s;

    // Decode the byte class and digit value.
    always_comb begin
        diff_s     = char_i - CH_0;
        is_digit_o = (char_i >= CH_0) && (char_i <= CH_9);
        is_nl_o    = (char_i == CH_NL);
        is_cr_o    = (char_i == CH_CR);
        is_minus_o = (char_i == CH_MINUS);
        if (is_digit_o) begin
            digit_o = diff_s[3:0];
        end else begin
            digit_o = 4'd0;
        end
    end

endmodule

// File: rtl/ascii_dec_parser.sv
// Streaming ASCII decimal parser: accumulates digits up to a newline and emits
// value, digit count and error code. Define ASCII_DEC_SIGNED_EN for leading '-'.
module ascii_dec_parser
    import ascii_dec_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [7:0]                      in_char,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0] out_ndigits,
    output logic [1:0]                      out_err
);

    localparam int ACC_W = WIDTH + 4;
    localparam int NDW   = $clog2(MAX_DIGITS + 1);

    localparam logic [ACC_W-1:0] LIM_U = {4'b0000, {WIDTH{1'b1}}};
    localparam logic [NDW-1:0]   MAXD  = NDW'(MAX_DIGITS);
    localparam logic [NDW-1:0]   ND_ONE = {{(NDW-1){1'b0}}, 1'b1};
`ifdef ASCII_DEC_SIGNED_EN
    localparam logic [ACC_W-1:0] ONE_W   = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] LIM_NEG = ONE_W << (WIDTH - 1);
    localparam logic [ACC_W-1:0] LIM_POS = LIM_NEG - ONE_W;
`endif

    state_e             state_q, state_d;
    err_e               err_q, err_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [NDW-1:0]     ndig_q, ndig_d;
    logic               neg_q, neg_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_value_q, out_value_d;
    logic [NDW-1:0]     out_ndigits_q, out_ndigits_d;
    logic [1:0]         out_err_q, out_err_d;

    logic               cc_is_digit_s, cc_is_nl_s, cc_is_cr_s, cc_is_minus_s;
    logic [3:0]         cc_digit_s;
    logic               xfer_in_s, xfer_out_s;
    logic [ACC_W-1:0]   acc_mul_s, limit_s;
    logic [WIDTH-1:0]   mag_s, signed_val_s;

    ascii_char_class u_class (
        .char_i     (in_char),
        .is_digit_o (cc_is_digit_s),
        .is_nl_o    (cc_is_nl_s),
        .is_cr_o    (cc_is_cr_s),
        .is_minus_o (cc_is_minus_s),
        .digit_o    (cc_digit_s)
    );

    // Datapath helpers: acc*10+d never wraps because ACC_W has 4 spare bits.
    always_comb begin
        xfer_in_s  = in_valid && in_ready_q;
        xfer_out_s = out_valid_q && out_ready;
        acc_mul_s  = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, cc_digit_s};
`ifdef ASCII_DEC_SIGNED_EN
        if (neg_q) begin
            limit_s = LIM_NEG;
        end else begin
            limit_s = LIM_POS;
        end
`else
        limit_s = LIM_U;
`endif
        mag_s = acc_q[WIDTH-1:0];
        if (neg_q) begin
            signed_val_s = ~mag_s + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            signed_val_s = mag_s;
        end
    end

    // Next-state logic for the parser FSM and its result registers.
    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        acc_d         = acc_q;
        ndig_d        = ndig_q;
        neg_d         = neg_q;
        out_valid_d   = out_valid_q;
        out_value_d   = out_value_q;
        out_ndigits_d = out_ndigits_q;
        out_err_d     = out_err_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer_in_s) begin
                    if (cc_is_cr_s) begin
                        state_d = ST_IDLE;
                    end else if (cc_is_digit_s) begin
                        state_d = ST_ACCUM;
                        acc_d   = {{(ACC_W-4){1'b0}}, cc_digit_s};
                        ndig_d  = ND_ONE;
                    end else if (cc_is_nl_s) begin
                        state_d = ST_DONE;
                        err_d   = ERR_EMPTY;
                    end else if (cc_is_minus_s) begin
`ifdef ASCII_DEC_SIGNED_EN
                        state_d = ST_ACCUM;
                        neg_d   = 1'b1;
                        ndig_d  = {NDW{1'b0}};
`else
                        state_d = ST_SKIP;
                        err_d   = ERR_BADCHAR;
`endif
                    end else begin
                        state_d = ST_SKIP;
                        err_d   = ERR_BADCHAR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (xfer_in_s) begin
                    if (cc_is_cr_s) begin
                        state_d = ST_ACCUM;
                    end else if (cc_is_digit_s) begin
                        if ((ndig_q >= MAXD) || (acc_mul_s > limit_s)) begin
                            state_d = ST_SKIP;
                            err_d   = ERR_OVF;
                        end else begin
                            acc_d  = acc_mul_s;
                            ndig_d = ndig_q + ND_ONE;
                        end
                    end else if (cc_is_nl_s) begin
                        state_d = ST_DONE;
                        if (ndig_q == {NDW{1'b0}}) begin
                            err_d = ERR_EMPTY;
                        end else begin
                            err_d = ERR_NONE;
                        end
                    end else begin
                        state_d = ST_SKIP;
                        err_d   = ERR_BADCHAR;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_SKIP: begin
                if (xfer_in_s && cc_is_nl_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SKIP;
                end
            end
            ST_DONE: begin
                if (xfer_out_s) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                    acc_d   = {ACC_W{1'b0}};
                    ndig_d  = {NDW{1'b0}};
                    neg_d   = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
                acc_d   = {ACC_W{1'b0}};
                ndig_d  = {NDW{1'b0}};
                neg_d   = 1'b0;
            end
        endcase

        // Result is captured on the DONE entry edge and cleared once consumed.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            out_valid_d   = 1'b1;
            out_ndigits_d = ndig_d;
            out_err_d     = err_d;
            if (err_d == ERR_NONE) begin
                out_value_d = signed_val_s;
            end else begin
                out_value_d = {WIDTH{1'b0}};
            end
        end else if (xfer_out_s) begin
            out_valid_d   = 1'b0;
            out_value_d   = {WIDTH{1'b0}};
            out_ndigits_d = {NDW{1'b0}};
            out_err_d     = ERR_NONE;
        end else begin
            out_valid_d = out_valid_q;
        end

        in_ready_d = (state_d != ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            err_q         <= ERR_NONE;
            acc_q         <= {ACC_W{1'b0}};
            ndig_q        <= {NDW{1'b0}};
            neg_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_value_q   <= {WIDTH{1'b0}};
            out_ndigits_q <= {NDW{1'b0}};
            out_err_q     <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            acc_q         <= acc_d;
            ndig_q        <= ndig_d;
            neg_q         <= neg_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_value_q   <= out_value_d;
            out_ndigits_q <= out_ndigits_d;
            out_err_q     <= out_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_value   = out_value_q;
    assign out_ndigits = out_ndigits_q;
    assign out_err     = out_err_q;

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Directed self-checking bench for ascii_dec_parser (WIDTH=16, MAX_DIGITS=5).
// Signed tests are compiled in when ASCII_DEC_SIGNED_EN is defined.
module tb_ascii_dec_parser;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_value;
    logic [2:0]  out_ndigits;
    logic [1:0]  out_err;

    int total;
    int bad;

    ascii_dec_parser #(.WIDTH(16), .MAX_DIGITS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_ndigits (out_ndigits),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] c);
        int n;
        n = 0;
        in_char  = c;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_byte_timeout in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_valid_timeout out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_value !== 16'd0) begin bad++; $display("FAIL rst_out_value got=%0d want=0", out_value); end
        total++; if (out_ndigits !== 3'd0) begin bad++; $display("FAIL rst_ndigits got=%0d want=0", out_ndigits); end
        total++; if (out_err !== 2'd0) begin bad++; $display("FAIL rst_err got=%0d want=0", out_err); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_str("42\n");
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t1_latency out_valid got=%b want=1", out_valid); end
        total++; if (out_value !== 16'd42) begin bad++; $display("FAIL t1_value got=%0d want=42", out_value); end
        total++; if (out_ndigits !== 3'd2) begin bad++; $display("FAIL t1_ndigits got=%0d want=2", out_ndigits); end
        total++; if (out_err !== 2'd0) begin bad++; $display("FAIL t1_err got=%0d want=0", out_err); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t1_in_ready_done got=%b want=0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_consumed out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t1_in_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_range();
        send_str("65535\n");
        wait_valid();
        total++; if (out_value !== 16'hFFFF) begin bad++; $display("FAIL t2_max_value got=%0d want=65535", out_value); end
        total++; if (out_err !== 2'd0) begin bad++; $display("FAIL t2_max_err got=%0d want=0", out_err); end
        total++; if (out_ndigits !== 3'd5) begin bad++; $display("FAIL t2_max_ndigits got=%0d want=5", out_ndigits); end
        consume();
        send_str("65536\n");
        wait_valid();
        total++; if (out_value !== 16'd0) begin bad++; $display("FAIL t2_ovf_value got=%0d want=0", out_value); end
        total++; if (out_err !== 2'd2) begin bad++; $display("FAIL t2_ovf_err got=%0d want=2", out_err); end
        consume();
        send_str("000000\n");
        wait_valid();
        total++; if (out_err !== 2'd2) begin bad++; $display("FAIL t2_digits_err got=%0d want=2", out_err); end
        consume();
        send_str("007\n");
        wait_valid();
        total++; if (out_value !== 16'd7) begin bad++; $display("FAIL t2_lead0_value got=%0d want=7", out_value); end
        total++; if (out_ndigits !== 3'd3) begin bad++; $display("FAIL t2_lead0_ndigits got=%0d want=3", out_ndigits); end
        consume();
    endtask

    task automatic test_badchar();
        send_str("4x7\n");
        wait_valid();
        total++; if (out_err !== 2'd1) begin bad++; $display("FAIL t3_bad_err got=%0d want=1", out_err); end
        total++; if (out_value !== 16'd0) begin bad++; $display("FAIL t3_bad_value got=%0d want=0", out_value); end
        consume();
        send_str("9\r\n");
        wait_valid();
        total++; if (out_value !== 16'd9) begin bad++; $display("FAIL t3_cr_value got=%0d want=9", out_value); end
        total++; if (out_err !== 2'd0) begin bad++; $display("FAIL t3_cr_err got=%0d want=0", out_err); end
        total++; if (out_ndigits !== 3'd1) begin bad++; $display("FAIL t3_cr_ndigits got=%0d want=1", out_ndigits); end
        consume();
        send_str("x9y\n");
        wait_valid();
        total++; if (out_err !== 2'd1) begin bad++; $display("FAIL t3_first_bad_err got=%0d want=1", out_err); end
        consume();
    endtask

    task automatic test_empty_hold();
        send_str("\n");
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t4_hold_valid cyc=%0d got=%b want=1", i, out_valid); end
            total++; if (out_err !== 2'd3) begin bad++; $display("FAIL t4_hold_err cyc=%0d got=%0d want=3", i, out_err); end
            total++; if (out_ndigits !== 3'd0) begin bad++; $display("FAIL t4_hold_nd cyc=%0d got=%0d want=0", i, out_ndigits); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t4_hold_in_ready cyc=%0d got=%b want=0", i, in_ready); end
            @(posedge clk); #1;
        end
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t4_release_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t4_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_mid_reset();
        send_str("12");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t5_no_output got=%b want=0", out_valid); end
        send_str("3\n");
        wait_valid();
        total++; if (out_value !== 16'd3) begin bad++; $display("FAIL t5_value got=%0d want=3", out_value); end
        total++; if (out_ndigits !== 3'd1) begin bad++; $display("FAIL t5_ndigits got=%0d want=1", out_ndigits); end
        consume();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_str("1\n");
        total++; if (out_value !== 16'd1) begin bad++; $display("FAIL b2b_first got=%0d want=1", out_value); end
        send_str("2\n");
        total++; if (out_value !== 16'd2) begin bad++; $display("FAIL b2b_second got=%0d want=2", out_value); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
    endtask

`ifdef ASCII_DEC_SIGNED_EN
    task automatic test_signed();
        send_str("-32768\n");
        wait_valid();
        total++; if (out_value !== 16'h8000) begin bad++; $display("FAIL t6_min_value got=%h want=8000", out_value); end
        total++; if (out_err !== 2'd0) begin bad++; $display("FAIL t6_min_err got=%0d want=0", out_err); end
        consume();
        send_str("-32769\n");
        wait_valid();
        total++; if (out_err !== 2'd2) begin bad++; $display("FAIL t6_ovf_err got=%0d want=2", out_err); end
        consume();
        send_str("5-\n");
        wait_valid();
        total++; if (out_err !== 2'd1) begin bad++; $display("FAIL t6_minus_late got=%0d want=1", out_err); end
        consume();
        send_str("-\n");
        wait_valid();
        total++; if (out_err !== 2'd3) begin bad++; $display("FAIL t6_minus_empty got=%0d want=3", out_err); end
        consume();
        send_str("32768\n");
        wait_valid();
        total++; if (out_err !== 2'd2) begin bad++; $display("FAIL t6_pos_ovf got=%0d want=2", out_err); end
        consume();
    endtask
`else
    task automatic test_signed();
        send_str("-5\n");
        wait_valid();
        total++; if (out_err !== 2'd1) begin bad++; $display("FAIL t6_minus_bad got=%0d want=1", out_err); end
        total++; if (out_value !== 16'd0) begin bad++; $display("FAIL t6_minus_value got=%0d want=0", out_value); end
        consume();
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_range();
        test_badchar();
        test_empty_hold();
        test_mid_reset();
        test_back_to_back();
        test_signed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
